// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg
//   Shared types and defaults for the vector checker response monitor.
//   - state_t : run-control states (IDLE, RUN, DONE)
//   - DEF_CNT_W / DEF_DATA_W : default counter and vector widths
//   - entry_t : one expected-table entry {mask, data} at the default width
package vector_checker_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mask sits in the upper half so a packed entry matches the {mask, data}
  // layout stored in vector_mem.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] mask;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/vector_mem.sv
// vector_mem
//   Expected-vector table: DEPTH entries of {mask, data}, synchronous write,
//   asynchronous (combinational) read, no reset so contents survive rst_n.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  {mask, data} to store
//   raddr  in  read address
//   rdata  out {mask, data} at raddr
module vector_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [2*DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vector_checker.sv
// vector_checker
//   Response monitor: compares each observed DUT sample, in order, against a
//   loaded table of masked expected vectors and reports mismatch count, first
//   failing index and pass/fail.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | table writable, waiting for start
//   RUN   | comparing one sample per obs_valid, index advancing
//   DONE  | results held until start or abort
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load_en/addr/data/mask  table write port (honoured only in IDLE)
//   num_vec               vectors to check, sampled on start (clipped to DEPTH)
//   start, abort          run control; abort wins over everything
//   obs_valid, obs_data   observed sample stream
//   busy, done, pass      run status (registered)
//   mismatch_count        saturating failing-sample count
//   first_fail_valid/idx  first failing sample index
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] load_mask,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  input  logic              abort,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx
);

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   index;
  logic [ADDR_W:0]     num_lat;
  logic [ADDR_W:0]     num_clip;
  logic [2*DATA_W-1:0] rd_entry;
  logic [DATA_W-1:0]   exp_data, exp_mask;
  logic                miss, last, sample, start_ok, addr_ok, mem_we;

  // Zero-extended compare keeps the range check meaningful for any DEPTH.
  assign addr_ok = ({1'b0, load_addr} < DEPTH_N);
  assign mem_we  = load_en && !abort && (state == IDLE) && addr_ok;

  vector_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata ({load_mask, load_data}),
    .raddr (index),
    .rdata (rd_entry)
  );

  assign exp_mask = rd_entry[2*DATA_W-1:DATA_W];
  assign exp_data = rd_entry[DATA_W-1:0];

  assign num_clip = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign miss     = |((obs_data ^ exp_data) & exp_mask);
  assign last     = (({1'b0, index} + (ADDR_W+1)'(1)) == num_lat);
  assign sample   = (state == RUN) && obs_valid && !abort;
  assign start_ok = start && !abort && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
        RUN:        if (obs_valid && last) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      index            <= '0;
      num_lat          <= '0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (abort) begin
        // Counters and first-fail fields stay for post-mortem debug.
        pass <= 1'b0;
      end else if (start_ok) begin
        mismatch_count   <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        index            <= '0;
        num_lat          <= num_clip;
        pass             <= (num_vec == '0);
      end else if (sample) begin
        if (miss) begin
          if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= index;
          end
        end
        index <= index + ADDR_W'(1);
        // Saturated count can never read back as zero, so this is exact.
        if (last) pass <= !miss && (mismatch_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
module tb_vector_checker;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0, load_mask = '0;
  logic [ADDR_W:0]   num_vec = '0;
  logic              start = 1'b0, abort = 1'b0, obs_valid = 1'b0;
  logic [DATA_W-1:0] obs_data = '0;

  logic              busy, done, pass, first_fail_valid;
  logic [7:0]        mismatch_count;
  logic [ADDR_W-1:0] first_fail_idx;
  logic              s_busy, s_done, s_pass, s_ffv;
  logic [1:0]        s_count;
  logic [ADDR_W-1:0] s_ffi;

  int n_vec = 0, n_err = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  vector_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_mask(load_mask), .num_vec(num_vec),
    .start(start), .abort(abort), .obs_valid(obs_valid), .obs_data(obs_data),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx));

  vector_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_mask(load_mask), .num_vec(num_vec),
    .start(start), .abort(abort), .obs_valid(obs_valid), .obs_data(obs_data),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_count(s_count),
    .first_fail_valid(s_ffv), .first_fail_idx(s_ffi));

  // Behavioural reference: table copy plus run bookkeeping in plain ints.
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [DATA_W-1:0] m_mask [DEPTH];
  int m_mode = M_IDLE, m_idx = 0, m_n = 0, m_miss = 0, m_ffi = 0;
  bit m_ffv = 0, m_pass = 0;

  initial for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_mask[i] = '0; end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_idx = 0; m_n = 0; m_miss = 0; m_ffi = 0; m_ffv = 0; m_pass = 0;
    end else if (abort) begin
      m_mode = M_IDLE; m_pass = 0;
    end else if (m_mode == M_RUN) begin
      if (obs_valid) begin
        if (((obs_data ^ m_data[m_idx]) & m_mask[m_idx]) != 0) begin
          if (!m_ffv) begin m_ffv = 1; m_ffi = m_idx; end
          m_miss++;
        end
        m_idx++;
        if (m_idx == m_n) begin m_mode = M_DONE; m_pass = (m_miss == 0); end
      end
    end else begin
      if (m_mode == M_IDLE && load_en) begin
        m_data[int'(load_addr)] = load_data;
        m_mask[int'(load_addr)] = load_mask;
      end
      if (start) begin
        m_miss = 0; m_ffv = 0; m_ffi = 0; m_idx = 0;
        m_n = (int'(num_vec) > DEPTH) ? DEPTH : int'(num_vec);
        m_mode = (m_n == 0) ? M_DONE : M_RUN;
        m_pass = (m_n == 0);
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",     64'(busy),             64'(m_mode == M_RUN));
      chk("done",     64'(done),             64'(m_mode == M_DONE));
      chk("pass",     64'(pass),             64'(m_pass));
      chk("count",    64'(mismatch_count),   64'(sat(m_miss, 255)));
      chk("ffv",      64'(first_fail_valid), 64'(m_ffv));
      chk("ffi",      64'(first_fail_idx),   64'(m_ffi));
      chk("s_count",  64'(s_count),          64'(sat(m_miss, 3)));
      chk("s_done",   64'(s_done),           64'(m_mode == M_DONE));
      chk("s_pass",   64'(s_pass),           64'(m_pass));
      chk("s_ffi",    64'(s_ffi),            64'(m_ffi));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    load_en = 1'b1; load_addr = 4'(a); load_data = d; load_mask = m;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic run_start(input int n);
    num_vec = 5'(n); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic sample(input logic [DATA_W-1:0] d);
    obs_valid = 1'b1; obs_data = d;
    cyc();
    obs_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  logic [DATA_W-1:0] vals [4];
  bit                pat [6];
  int                k, r;

  initial begin
    #2 rst_n = 1'b0;
    chk_on = 1;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst busy",  64'(busy), 64'(0));
    chk("rst done",  64'(done), 64'(0));
    chk("rst pass",  64'(pass), 64'(0));
    chk("rst count", 64'(mismatch_count), 64'(0));
    chk("rst ffv",   64'(first_fail_valid), 64'(0));

    for (int i = 0; i < DEPTH; i++) load(i, $urandom, 32'hFFFF_FFFF);

    // Basic full-mask pass.
    vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'h0; vals[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) load(i, vals[i], 32'hFFFF_FFFF);
    run_start(4);
    chk("t1 busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) sample(vals[i]);
    chk("t1 done",  64'(done), 64'(1));
    chk("t1 pass",  64'(pass), 64'(1));
    chk("t1 count", 64'(mismatch_count), 64'(0));
    chk("t1 ffv",   64'(first_fail_valid), 64'(0));
    chk("t1 busy0", 64'(busy), 64'(0));

    // One bad sample at index 2.
    run_start(4);
    sample(32'h0); sample(32'h1); sample(32'h5); sample(32'hFFFF_FFFF);
    chk("t2 count", 64'(mismatch_count), 64'(1));
    chk("t2 ffi",   64'(first_fail_idx), 64'(2));
    chk("t2 ffv",   64'(first_fail_valid), 64'(1));
    chk("t2 pass",  64'(pass), 64'(0));

    // Masked compare.
    do_abort();
    load(0, 32'h12, 32'h0000_00FF);
    run_start(1);
    sample(32'hABCD_0012);
    chk("t3 mask pass", 64'(pass), 64'(1));
    run_start(1);
    sample(32'h0000_0013);
    chk("t3 mask count", 64'(mismatch_count), 64'(1));
    chk("t3 mask pass0", 64'(pass), 64'(0));

    // Stalls: 3 compares over 6 cycles.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    vals[0] = 32'h0000_0012;
    run_start(3);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      obs_valid = pat[i];
      obs_data  = pat[i] ? vals[k] : 32'hDEAD_BEEF;
      if (pat[i]) k++;
      cyc();
      if (i == 4) chk("t4 not done", 64'(done), 64'(0));
    end
    obs_valid = 1'b0;
    chk("t4 done",  64'(done), 64'(1));
    chk("t4 pass",  64'(pass), 64'(1));
    run_start(0);
    chk("t4 zero done", 64'(done), 64'(1));
    chk("t4 zero pass", 64'(pass), 64'(1));
    chk("t4 zero busy", 64'(busy), 64'(0));

    // Saturation on the CNT_W=2 instance.
    run_start(6);
    for (int i = 0; i < 6; i++) sample(~m_data[i]);
    chk("t5 count",   64'(mismatch_count), 64'(6));
    chk("t5 s_count", 64'(s_count), 64'(3));
    chk("t5 s_ffi",   64'(s_ffi), 64'(0));

    // Abort with start/load_en/obs_valid colliding.
    run_start(6);
    sample(~m_data[0]); sample(~m_data[1]);
    abort = 1'b1; start = 1'b1; load_en = 1'b1; load_addr = 4'd1;
    load_data = 32'hDEAD; load_mask = 32'hFFFF_FFFF; obs_valid = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0; load_en = 1'b0; obs_valid = 1'b0;
    chk("t6 busy",  64'(busy), 64'(0));
    chk("t6 done",  64'(done), 64'(0));
    chk("t6 count", 64'(mismatch_count), 64'(2));
    chk("t6 ffv",   64'(first_fail_valid), 64'(1));
    run_start(2);
    sample(32'h12); sample(32'h1);
    chk("t6 table pass", 64'(pass), 64'(1));

    // Asynchronous reset mid-run.
    run_start(4);
    sample(32'hFFFF_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("t7 busy",  64'(busy), 64'(0));
    chk("t7 count", 64'(mismatch_count), 64'(0));
    chk("t7 ffv",   64'(first_fail_valid), 64'(0));
    chk("t7 done",  64'(done), 64'(0));
    cyc();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      load_en = 0; start = 0; abort = 0; obs_valid = 0;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        abort = 1'b1; start = 1'($urandom); load_en = 1'($urandom);
        load_addr = 4'($urandom); load_data = $urandom; load_mask = $urandom;
        obs_valid = 1'($urandom);
      end else if (m_mode != M_RUN) begin
        if (r < 40) begin
          load_en = 1'b1; load_addr = 4'($urandom); load_data = $urandom;
          load_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
        end else if (r < 60) begin
          start = 1'b1; num_vec = 5'($urandom_range(0, 20));
        end
      end else begin
        obs_valid = ($urandom_range(0, 3) != 0);
        obs_data  = ($urandom_range(0, 3) == 0) ? $urandom
                  : (m_data[m_idx] ^ ($urandom & ~m_mask[m_idx]));
        if (r < 6) begin start = 1'b1; num_vec = 5'($urandom_range(0, 31)); end
        if (r >= 6 && r < 10) begin load_en = 1'b1; load_addr = 4'($urandom); load_data = $urandom; end
      end
      cyc();
    end
    load_en = 0; start = 0; abort = 0; obs_valid = 0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
# vector_checker

Self-checking response monitor for the TOP verification flow: the receiving end of the vector stimulus path. It holds a loaded table of expected output vectors with per-bit masks and compares each DUT output sample, in order, against the next entry. It reports mismatch count, first failing index and pass/fail so regressions no longer depend on waveform inspection of the VCD dump.

## Interface
Parameters:
- DATA_W, 32, width of one observed/expected vector
- DEPTH, 16, number of expected-vector entries
- ADDR_W, $clog2(DEPTH), index width
- CNT_W, 8, mismatch counter width

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- load_en  in  1  write strobe for expected table
- load_addr  in  ADDR_W  table entry to write
- load_data  in  DATA_W  expected value
- load_mask  in  DATA_W  compare mask; 1 = bit checked, 0 = don't-care
- num_vec  in  ADDR_W+1  vectors to check, 0..DEPTH, sampled on start
- start  in  1  begin a check run
- abort  in  1  terminate a run and return to IDLE
- obs_valid  in  1  obs_data holds a DUT sample this cycle
- obs_data  in  DATA_W  observed DUT output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done with zero mismatches
- mismatch_count  out  CNT_W  failing samples in the current/last run
- first_fail_valid  out  1  at least one mismatch recorded
- first_fail_idx  out  ADDR_W  index of first failing sample

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: load_en=1 writes {load_mask, load_data} to entry load_addr; addresses >= DEPTH are ignored. load_en in RUN or DONE is ignored.
- start in IDLE or DONE: clears mismatch_count, first_fail_valid, first_fail_idx, pass, done; latches num_vec; index <= 0.
  - num_vec = 0 -> DONE directly, pass=1.
  - num_vec > DEPTH -> treated as DEPTH.
  - otherwise -> RUN.
- RUN, obs_valid=1: mismatch = |((obs_data ^ exp_data[index]) & exp_mask[index]). On mismatch, mismatch_count increments, saturating at 2^CNT_W-1. The first mismatch sets first_fail_valid and first_fail_idx <= index. index increments.
- On the sample at index = num_vec-1 -> DONE. pass = (final mismatch_count == 0).
- RUN, obs_valid=0: no change (stall).
- start during RUN: ignored.
- abort (any state): -> IDLE, done=0, pass=0. Counters and first-fail fields keep their values for debug. abort has priority over start, obs_valid and load_en in the same cycle.
- DONE: holds all results until start or abort.
- Reset mid-run: immediate return to IDLE, run lost. Table contents are not reset.

## Timing
- Reset values: busy=0, done=0, pass=0, mismatch_count=0, first_fail_valid=0, first_fail_idx=0.
- All outputs are registered.
- Table read is combinational at index. Compare result lands in mismatch_count and first_fail_* on the edge that samples obs_valid, so it is visible 1 cycle after the sample.
- done and pass rise on the same edge that consumes the last sample, i.e. 1 cycle after the final obs_valid.
- Throughput is one sample per cycle.
- busy rises the cycle after start and falls with done.
- A load_en write in cycle n is visible to a run started in cycle n+1.

## Structure
- Package vector_checker_pkg holds:
  - state enum: IDLE, RUN, DONE
  - default CNT_W
  - a typedef for a table entry struct {mask, data}
- Sub-module vector_mem: DEPTH x 2*DATA_W, synchronous write, asynchronous read, no reset.
- vector_checker contains the FSM, index/counter datapath and compare logic.

## Test plan
- Load 4 entries 0x0,0x1,0x0,0xFFFF_FFFF with full mask, num_vec=4, drive the same 4 values back-to-back -> done one cycle after the 4th sample, pass=1, mismatch_count=0, first_fail_valid=0.
- Same table, drive sample 2 as 0x5 -> mismatch_count=1, first_fail_idx=2, pass=0.
- Entry 0 mask 0x0000_00FF, data 0x12; drive 0xABCD_0012 -> no mismatch. Drive 0x0000_0013 -> mismatch.
- num_vec=3 with obs_valid toggling 1,0,0,1,0,1 -> exactly 3 compares, done after the 6th cycle. num_vec=0 -> done and pass on the cycle after start.
- CNT_W=2, 6 failing samples -> mismatch_count saturates at 3, first_fail_idx=0.
- Assert abort after 2 samples, with start and load_en high in the same cycle -> IDLE, busy=0, done=0, table unchanged. Async rst_n pulse mid-run -> all outputs 0 without waiting for a clock edge.
